lsu_ctrl: RTL and testbench

- Sequential, parametrised load/store unit between the core execute stage and the shared system bus.
- Accepts one request at a time, checks alignment and legality, and arbitrates for the bus with a REQ/GNT handshake.
- Waits for a bus ACK and steers byte lanes: byte enables on stores, sign/zero extension on loads.
- Raises a stall to the core while busy; reports misalignment, illegal ops and bus timeouts as error codes.

---
 rtl/lsu_ctrl_pkg.sv | 38 +++
 rtl/lsu_ctrl_if.sv | 40 ++++
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu_ctrl.sv | 153 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: access sizes, error codes and
// FSM states, plus the alignment rule used at request acceptance.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        HB_BYTE  = 2'b00,
        HB_HALF  = 2'b01,
        HB_WORD  = 2'b10,
        HB_DWORD = 2'b11
    } hb_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_REQ    = 2'b01,
        S_ACCESS = 2'b10,
        S_DONE   = 2'b11
    } state_e;

    // Natural alignment: address modulo access size must be zero.
    function automatic logic is_misaligned(input logic [2:0] lo, input hb_e hb);
        logic mis;
        case (hb)
            HB_BYTE: mis = 1'b0;
            HB_HALF: mis = lo[0];
            HB_WORD: mis = |lo[1:0];
            default: mis = |lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and system-bus signals of the load/store unit.
interface lsu_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  i_VALID;
    logic [DATA_W-1:0]     i_WDATA;
    logic [ADDR_W-1:0]     i_ADDR;
    logic                  i_WE;
    logic                  i_RE;
    logic [1:0]            i_HB;
    logic                  i_ULOAD;
    logic [DATA_W-1:0]     o_RDATA;
    logic                  o_BUSY;
    logic                  o_DONE;
    logic [1:0]            o_ERR;
    logic [DATA_W-1:0]     i_BUS_RDATA;
    logic [DATA_W-1:0]     o_BUS_WDATA;
    logic [ADDR_W-1:0]     o_BUS_ADDR;
    logic [DATA_W/8-1:0]   o_BUS_BE;
    logic                  o_BUS_WE;
    logic                  o_BUS_RE;
    logic                  o_BUS_REQ;
    logic                  i_BUS_GNT;
    logic                  i_BUS_ACK;

    modport slave (
        input  i_VALID, i_WDATA, i_ADDR, i_WE, i_RE, i_HB, i_ULOAD,
        input  i_BUS_RDATA, i_BUS_GNT, i_BUS_ACK,
        output o_RDATA, o_BUSY, o_DONE, o_ERR,
        output o_BUS_WDATA, o_BUS_ADDR, o_BUS_BE, o_BUS_WE, o_BUS_RE, o_BUS_REQ
    );

    modport master (
        output i_VALID, i_WDATA, i_ADDR, i_WE, i_RE, i_HB, i_ULOAD,
        output i_BUS_RDATA, i_BUS_GNT, i_BUS_ACK,
        input  o_RDATA, o_BUSY, o_DONE, o_ERR,
        input  o_BUS_WDATA, o_BUS_ADDR, o_BUS_BE, o_BUS_WE, o_BUS_RE, o_BUS_REQ
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables and store replication toward the bus,
// lane extraction and sign/zero extension of load data coming back.
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LANE_W = $clog2(NB)
) (
    input  logic [LANE_W-1:0] lane,
    input  hb_e               hb,
    input  logic              uload,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [DATA_W-1:0] shifted;

    // Park the field at the top, then shift back down arithmetically or logically.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input int sz, input logic zext);
        logic signed [DATA_W-1:0] t;
        t = $signed(v << (DATA_W - sz));
        if (zext)
            return $unsigned(t) >> (DATA_W - sz);
        else
            return $unsigned(t >>> (DATA_W - sz));
    endfunction

    always_comb begin
        shifted   = bus_rdata >> {lane, 3'b000};
        be        = '1;
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (hb)
            HB_BYTE: begin
                be        = NB'(1) << lane;
                wdata_rep = {NB{wdata[7:0]}};
                rdata_ext = extend(shifted, 8, uload);
            end
            HB_HALF: begin
                be        = NB'(2'b11) << lane;
                wdata_rep = {(NB/2){wdata[15:0]}};
                rdata_ext = extend(shifted, 16, uload);
            end
            HB_WORD: begin
                be        = NB'(4'hF) << lane;
                wdata_rep = {(NB/4){wdata[31:0]}};
                rdata_ext = extend(shifted, 32, uload);
            end
            default: begin
                be        = '1;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one core request, checks legality, runs a
// REQ/GNT/ACK bus transfer with timeout and returns a one-cycle completion.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic        i_CLK,
    input logic        i_RST,
    lsu_ctrl_if.slave  bus
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               re_q, re_d;
    hb_e                hb_q, hb_d;
    logic               uload_q, uload_d;
    err_e               err_q, err_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    hb_e                hb_in;
    logic               accept, illegal_req, misaligned_req, legal_accept;
    logic               active, timeout_hit;
    logic [NB-1:0]      be_w;
    logic [DATA_W-1:0]  wrep_w, rext_w;

    assign hb_in          = hb_e'(bus.i_HB);
    assign accept         = (state_q == S_IDLE) & bus.i_VALID & (bus.i_WE | bus.i_RE);
    assign illegal_req    = (bus.i_WE & bus.i_RE) | ((hb_in == HB_DWORD) && (DATA_W == 32));
    assign misaligned_req = is_misaligned(bus.i_ADDR[2:0], hb_in);
    assign legal_accept   = accept & ~illegal_req & ~misaligned_req;
    assign active         = (state_q == S_REQ) || (state_q == S_ACCESS);
    assign timeout_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .lane      (addr_q[LANE_W-1:0]),
        .hb        (hb_q),
        .uload     (uload_q),
        .wdata     (wdata_q),
        .bus_rdata (bus.i_BUS_RDATA),
        .be        (be_w),
        .wdata_rep (wrep_w),
        .rdata_ext (rext_w)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            hb_q    <= HB_BYTE;
            uload_q <= 1'b0;
            err_q   <= ERR_OK;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            hb_q    <= hb_d;
            uload_q <= uload_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        hb_d    = hb_q;
        uload_d = uload_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (illegal_req) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = S_DONE;
                    end else if (misaligned_req) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = bus.i_ADDR;
                        wdata_d = bus.i_WDATA;
                        we_d    = bus.i_WE;
                        re_d    = bus.i_RE;
                        hb_d    = hb_in;
                        uload_d = bus.i_ULOAD;
                        err_d   = ERR_OK;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_hit) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_DONE;
                end else if (bus.i_BUS_GNT) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // ACK takes priority over a timeout landing in the same cycle.
                if (bus.i_BUS_ACK) begin
                    if (re_q)
                        rdata_d = rext_w;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_RDATA     = rdata_q;
        bus.o_BUSY      = legal_accept | active;
        bus.o_DONE      = (state_q == S_DONE);
        bus.o_ERR       = (state_q == S_DONE) ? err_q : ERR_OK;
        bus.o_BUS_REQ   = active;
        bus.o_BUS_WE    = active & we_q;
        bus.o_BUS_RE    = active & re_q;
        bus.o_BUS_BE    = active ? be_w : '0;
        bus.o_BUS_WDATA = active ? wrep_w : '0;
        bus.o_BUS_ADDR  = active ? {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stores, loads, error paths, timeout and reset.
module tb_lsu_ctrl;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lsu_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) lif ();

    lsu_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (lif)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    int          done_cyc, last_req;
    logic        busy_acc, req_seen, s_we, s_re;
    logic [1:0]  s_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in the next cycle and plays the bus side until o_DONE.
    task automatic run_txn(input logic we, input logic re, input logic [1:0] hb,
                           input logic ul, input logic [31:0] addr, input logic [31:0] wd,
                           input int gnt_c, input int ack_c, input logic [31:0] rd);
        int cyc;
        step();
        lif.i_VALID = 1'b1; lif.i_WE = we; lif.i_RE = re; lif.i_HB = hb;
        lif.i_ULOAD = ul; lif.i_ADDR = addr; lif.i_WDATA = wd;
        #1;
        busy_acc = lif.o_BUSY;
        cyc = 0; done_cyc = -1; last_req = -1; req_seen = 1'b0;
        s_addr = '0; s_be = '0; s_wdata = '0; s_we = 1'b0; s_re = 1'b0;
        while (cyc < 30 && done_cyc < 0) begin
            step();
            cyc++;
            lif.i_VALID     = 1'b0;
            lif.i_BUS_GNT   = (cyc == gnt_c);
            lif.i_BUS_ACK   = (cyc == ack_c);
            lif.i_BUS_RDATA = rd;
            #1;
            if (lif.o_BUS_REQ) begin
                if (!req_seen) begin
                    s_addr = lif.o_BUS_ADDR; s_be = lif.o_BUS_BE; s_wdata = lif.o_BUS_WDATA;
                    s_we = lif.o_BUS_WE; s_re = lif.o_BUS_RE;
                end
                req_seen = 1'b1;
                last_req = cyc;
            end
            if (lif.o_DONE) begin
                done_cyc = cyc; s_err = lif.o_ERR; s_rdata = lif.o_RDATA;
            end
        end
        lif.i_BUS_GNT = 1'b0;
        lif.i_BUS_ACK = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if ({lif.o_RDATA, lif.o_BUSY, lif.o_DONE, lif.o_ERR, lif.o_BUS_REQ, lif.o_BUS_WE,
             lif.o_BUS_RE, lif.o_BUS_BE, lif.o_BUS_ADDR, lif.o_BUS_WDATA} !== '0) begin
            errs++; $display("FAIL reset_outputs: some output nonzero during reset, rdata=%h busy=%b req=%b",
                             lif.o_RDATA, lif.o_BUSY, lif.o_BUS_REQ);
        end
        rst = 1'b0;
    endtask

    task automatic test_no_op();
        step();
        lif.i_VALID = 1'b1; lif.i_WE = 1'b0; lif.i_RE = 1'b0;
        #1;
        vecs++;
        if (lif.o_BUSY !== 1'b0) begin errs++; $display("FAIL noop_busy got=%b exp=0", lif.o_BUSY); end
        step();
        lif.i_VALID = 1'b0;
        #1;
        vecs++;
        if ({lif.o_BUS_REQ, lif.o_DONE} !== 2'b00) begin
            errs++; $display("FAIL noop_idle got req,done=%b exp=00", {lif.o_BUS_REQ, lif.o_DONE});
        end
    endtask

    task automatic test_word_store();
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'hDEADBEEF, 2, 3, 32'h0);
        vecs++; if (busy_acc !== 1'b1) begin errs++; $display("FAIL wst_busy got=%b exp=1", busy_acc); end
        vecs++; if (done_cyc !== 4) begin errs++; $display("FAIL wst_latency got=%0d exp=4", done_cyc); end
        vecs++; if (s_err !== 2'b00) begin errs++; $display("FAIL wst_err got=%b exp=00", s_err); end
        vecs++; if (s_addr !== 32'h1000) begin errs++; $display("FAIL wst_addr got=%h exp=00001000", s_addr); end
        vecs++; if (s_be !== 4'hF) begin errs++; $display("FAIL wst_be got=%b exp=1111", s_be); end
        vecs++; if (s_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL wst_wdata got=%h exp=deadbeef", s_wdata); end
        vecs++; if ({s_we, s_re} !== 2'b10) begin errs++; $display("FAIL wst_we_re got=%b exp=10", {s_we, s_re}); end
    endtask

    task automatic test_byte_load();
        run_txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h1003, 32'h0, 1, 2, 32'h80AABBCC);
        vecs++; if (done_cyc !== 3) begin errs++; $display("FAIL lb_latency got=%0d exp=3", done_cyc); end
        vecs++; if (s_rdata !== 32'hFFFFFF80) begin errs++; $display("FAIL lb_sext got=%h exp=ffffff80", s_rdata); end
        vecs++; if (s_be !== 4'b1000) begin errs++; $display("FAIL lb_be got=%b exp=1000", s_be); end
        vecs++; if (s_addr !== 32'h1000) begin errs++; $display("FAIL lb_addr got=%h exp=00001000", s_addr); end
        run_txn(1'b0, 1'b1, 2'b00, 1'b1, 32'h1003, 32'h0, 1, 2, 32'h80AABBCC);
        vecs++; if (s_rdata !== 32'h00000080) begin errs++; $display("FAIL lbu_zext got=%h exp=00000080", s_rdata); end
        run_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h0, 1, 2, 32'h80010000);
        vecs++; if (s_rdata !== 32'hFFFF8001) begin errs++; $display("FAIL lh_sext got=%h exp=ffff8001", s_rdata); end
        run_txn(1'b0, 1'b1, 2'b00, 1'b1, 32'h1003, 32'h0, 1, 2, 32'h80AABBCC);
    endtask

    task automatic test_half_store();
        run_txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h2002, 32'h00001234, 1, 2, 32'hFFFFFFFF);
        vecs++; if (s_be !== 4'b1100) begin errs++; $display("FAIL sh_be got=%b exp=1100", s_be); end
        vecs++; if (s_wdata !== 32'h12341234) begin errs++; $display("FAIL sh_wdata got=%h exp=12341234", s_wdata); end
        vecs++; if (s_rdata !== 32'h00000080) begin errs++; $display("FAIL sh_rdata_kept got=%h exp=00000080", s_rdata); end
    endtask

    task automatic test_errors();
        run_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h2001, 32'h0, 1, 2, 32'h0);
        vecs++; if (req_seen !== 1'b0) begin errs++; $display("FAIL mis_no_req got=%b exp=0", req_seen); end
        vecs++; if (done_cyc !== 1) begin errs++; $display("FAIL mis_latency got=%0d exp=1", done_cyc); end
        vecs++; if (s_err !== 2'b01) begin errs++; $display("FAIL mis_err got=%b exp=01", s_err); end
        run_txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h3000, 32'h0, 1, 2, 32'h0);
        vecs++; if (req_seen !== 1'b0) begin errs++; $display("FAIL ill_no_req got=%b exp=0", req_seen); end
        vecs++; if (s_err !== 2'b11) begin errs++; $display("FAIL ill_err got=%b exp=11", s_err); end
        run_txn(1'b0, 1'b1, 2'b11, 1'b0, 32'h3000, 32'h0, 1, 2, 32'h0);
        vecs++; if (s_err !== 2'b11) begin errs++; $display("FAIL dword32_err got=%b exp=11", s_err); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h3000, 32'h0, 99, 99, 32'h0);
        vecs++; if (done_cyc !== 9) begin errs++; $display("FAIL to_latency got=%0d exp=9", done_cyc); end
        vecs++; if (last_req !== 8) begin errs++; $display("FAIL to_last_req got=%0d exp=8", last_req); end
        vecs++; if (s_err !== 2'b10) begin errs++; $display("FAIL to_err got=%b exp=10", s_err); end
        run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h3000, 32'h0, 1, 8, 32'h12345678);
        vecs++; if (done_cyc !== 9) begin errs++; $display("FAIL to_ack_latency got=%0d exp=9", done_cyc); end
        vecs++; if (s_err !== 2'b00) begin errs++; $display("FAIL to_ack_err got=%b exp=00", s_err); end
        vecs++; if (s_rdata !== 32'h12345678) begin errs++; $display("FAIL to_ack_rdata got=%h exp=12345678", s_rdata); end
        run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h3000, 32'h0, 1, 1, 32'hAAAA5555);
        vecs++; if (done_cyc !== 9) begin errs++; $display("FAIL ack_in_req_latency got=%0d exp=9", done_cyc); end
        vecs++; if (s_err !== 2'b10) begin errs++; $display("FAIL ack_in_req_err got=%b exp=10", s_err); end
    endtask

    task automatic test_reset_mid_access();
        logic quiet;
        step();
        lif.i_VALID = 1'b1; lif.i_WE = 1'b0; lif.i_RE = 1'b1; lif.i_HB = 2'b10;
        lif.i_ULOAD = 1'b0; lif.i_ADDR = 32'h4000;
        step();
        lif.i_VALID = 1'b0; lif.i_BUS_GNT = 1'b1;
        step();
        lif.i_BUS_GNT = 1'b0;
        #1;
        vecs++; if (lif.o_BUS_REQ !== 1'b1) begin errs++; $display("FAIL rst_mid_in_access got=%b exp=1", lif.o_BUS_REQ); end
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({lif.o_RDATA, lif.o_BUSY, lif.o_DONE, lif.o_ERR, lif.o_BUS_REQ, lif.o_BUS_WE,
             lif.o_BUS_RE, lif.o_BUS_BE, lif.o_BUS_ADDR, lif.o_BUS_WDATA} !== '0) begin
            errs++; $display("FAIL rst_mid_outputs: nonzero, rdata=%h req=%b busy=%b",
                             lif.o_RDATA, lif.o_BUS_REQ, lif.o_BUSY);
        end
        step();
        step();
        rst = 1'b0;
        quiet = 1'b1;
        lif.i_BUS_ACK = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (lif.o_DONE !== 1'b0 || lif.o_BUS_REQ !== 1'b0) quiet = 1'b0;
        end
        lif.i_BUS_ACK = 1'b0;
        vecs++; if (quiet !== 1'b1) begin errs++; $display("FAIL rst_mid_no_done got=0 exp=1"); end
        run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h4000, 32'h0, 1, 2, 32'h00000055);
        vecs++; if (done_cyc !== 3) begin errs++; $display("FAIL rst_after_latency got=%0d exp=3", done_cyc); end
        vecs++; if (s_rdata !== 32'h00000055) begin errs++; $display("FAIL rst_after_rdata got=%h exp=00000055", s_rdata); end
    endtask

    initial begin
        lif.i_VALID = 1'b0; lif.i_WDATA = '0; lif.i_ADDR = '0; lif.i_WE = 1'b0;
        lif.i_RE = 1'b0; lif.i_HB = 2'b00; lif.i_ULOAD = 1'b0;
        lif.i_BUS_RDATA = '0; lif.i_BUS_GNT = 1'b0; lif.i_BUS_ACK = 1'b0;
        test_reset();
        test_no_op();
        test_word_store();
        test_byte_load();
        test_half_store();
        test_errors();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
